id_ex_stage: RTL

Decode-to-execute pipeline stage of the RISC-V core. It captures decoded operands and control, then drives the ALU's A, B and OPERATION inputs. It resolves data hazards in two ways: operand forwarding from the EX/MEM and MEM/WB stages, and load-use bubble insertion. It also produces the rs2 store data and the destination and control fields consumed by the memory stage.

---
 rtl/id_ex_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register driving ALU operands, with forwarding and load-use hazard detection.
// Define FORWARDING_EN for EX/MEM and MEM/WB forwarding; without it, every RAW dependency interlocks via HAZARD.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [3:0]       in_operation,
    input  logic             in_alusrc,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] pc,
    output logic [4:0]       rd,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             valid,
    output logic             hazard
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [3:0]       operation;
        logic             alusrc;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } entry_t;

    entry_t r, in_e;
    logic load_use, interlock;
    logic [WIDTH-1:0] fa, fb;

    assign in_e = '{valid: in_valid, pc: in_pc, rs1_data: in_rs1_data, rs2_data: in_rs2_data,
                    imm: in_imm, rs1: in_rs1, rs2: in_rs2, rd: in_rd, operation: in_operation,
                    alusrc: in_alusrc, regwrite: in_regwrite, memread: in_memread, memwrite: in_memwrite};

    assign load_use = r.valid & r.memread & in_valid & (r.rd != 5'd0) & ((r.rd == in_rs1) | (r.rd == in_rs2));

`ifdef FORWARDING_EN
    function automatic logic [WIDTH-1:0] fwd(input logic [4:0] s, input logic [WIDTH-1:0] d);
        return (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == s) ? exmem_result :
               (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == s) ? memwb_data : d;
    endfunction
    assign fa = fwd(r.rs1, r.rs1_data);
    assign fb = fwd(r.rs2, r.rs2_data);
    assign interlock = 1'b0;
`else
    // Any in-flight producer of a source register blocks issue until it retires.
    function automatic logic busy(input logic [4:0] s);
        return s != 5'd0 && ((r.regwrite && r.rd == s) || (exmem_regwrite && exmem_rd == s) ||
                             (memwb_regwrite && memwb_rd == s));
    endfunction
    assign fa = r.rs1_data;
    assign fb = r.rs2_data;
    assign interlock = in_valid & (busy(in_rs1) | busy(in_rs2));
    logic unused_fwd;
    assign unused_fwd = ^{exmem_result, memwb_data, r.rs1, r.rs2};
`endif

    assign hazard = rst_n & (load_use | interlock);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= '0;
        else if (flush || (!stall && hazard)) r <= '0;
        else if (!stall) r <= in_e;
    end

    assign a          = fa;
    assign store_data = fb;
    assign b          = r.alusrc ? r.imm : fb;
    assign operation  = r.operation;
    assign pc         = r.pc;
    assign rd         = r.rd;
    assign regwrite   = r.regwrite;
    assign memread    = r.memread;
    assign memwrite   = r.memwrite;
    assign valid      = r.valid;
endmodule
